// File: rtl/cfg_loader.sv
// Header-plus-payload word loader that serializes one tile's configuration frame
// into the start/bit/valid protocol expected at the configuration chain head.
module cfg_loader #(
  parameter int unsigned IdWidth  = 3,
  parameter int unsigned LenWidth = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic        abort_i,
  output logic        cfg_in_start_o,
  output logic        cfg_bit_in_o,
  output logic        cfg_bit_in_valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned IdCntW = (IdWidth > 1) ? $clog2(IdWidth) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StId, StData, StWaitWord} state_e;

  state_e              state_q, state_d;
  logic [IdWidth-1:0]  id_q, id_d;
  logic [IdCntW-1:0]   id_cnt_q, id_cnt_d;
  logic [LenWidth-1:0] rem_q, rem_d;
  logic [31:0]         shift_q, shift_d;
  logic [4:0]          bit_idx_q, bit_idx_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  always_comb begin
    state_d            = state_q;
    id_d               = id_q;
    id_cnt_d           = id_cnt_q;
    rem_d              = rem_q;
    shift_d            = shift_q;
    bit_idx_d          = bit_idx_q;
    done_d             = 1'b0;
    err_d              = 1'b0;
    s_ready_o          = 1'b0;
    cfg_in_start_o     = 1'b0;
    cfg_bit_in_o       = 1'b0;
    cfg_bit_in_valid_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          id_d  = s_data_i[IdWidth-1:0];
          rem_d = s_data_i[16 +: LenWidth];
          if (s_data_i[16 +: LenWidth] == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        cfg_in_start_o = 1'b1;
        id_cnt_d       = '0;
        state_d        = StId;
      end
      StId: begin
        // ID register shifts left so its MSB is always the bit on the wire.
        cfg_bit_in_valid_o = 1'b1;
        cfg_bit_in_o       = id_q[IdWidth-1];
        id_d               = id_q << 1;
        id_cnt_d           = id_cnt_q + 1'b1;
        if (id_cnt_q == IdCntW'(IdWidth - 1)) begin
          state_d = StWaitWord;
        end
      end
      StWaitWord: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          shift_d   = s_data_i;
          bit_idx_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        cfg_bit_in_valid_o = 1'b1;
        cfg_bit_in_o       = shift_q[0];
        rem_d              = rem_q - 1'b1;
        shift_d            = shift_q >> 1;
        bit_idx_d          = bit_idx_q + 1'b1;
        if (rem_q == LenWidth'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (bit_idx_q == 5'd31) begin
          // Next word may arrive in the bit-31 cycle to keep the stream gapless.
          s_ready_o = 1'b1;
          if (s_valid_i) begin
            shift_d   = s_data_i;
            bit_idx_d = '0;
          end else begin
            state_d = StWaitWord;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      id_q      <= '0;
      id_cnt_q  <= '0;
      rem_q     <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      id_cnt_q  <= id_cnt_d;
      rem_q     <= rem_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_cfg_loader.sv
// Randomized and directed frames checked against a bit-stream model of the loader.
module tb_cfg_loader;

  localparam int IdW = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        abort = 1'b0;
  logic        s_ready, cfg_in_start, cfg_bit_in, cfg_bit_in_valid, busy, done, err;

  cfg_loader dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .s_data_i           (s_data),
    .s_valid_i          (s_valid),
    .s_ready_o          (s_ready),
    .abort_i            (abort),
    .cfg_in_start_o     (cfg_in_start),
    .cfg_bit_in_o       (cfg_bit_in),
    .cfg_bit_in_valid_o (cfg_bit_in_valid),
    .busy_o             (busy),
    .done_o             (done),
    .err_o              (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Passive monitor: the whole serial stream is logged, frames take snapshots.
  int cyc = 0;
  bit rec_q[$];
  int rec_cyc[$];
  int start_cnt = 0, start_cyc = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0, viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cfg_in_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (cfg_bit_in_valid) begin
        rec_q.push_back(cfg_bit_in);
        rec_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err) err_cnt++;
      if (done && err) viol++;
      if (cfg_in_start && cfg_bit_in_valid) viol++;
      if (!busy && (cfg_in_start || cfg_bit_in_valid)) viol++;
    end
  end

  logic [31:0] words [8];

  task automatic run_frame(input int id, input int n, input int gap_word, input int gap_len,
                           input int abort_at);
    int nw, total, idx, gap, hs_cyc, base, s0, d0, e0, v0, tail, got_n, exp_pay, mism, e;
    bit aborted, fin;
    logic [31:0] hdr;
    nw = (n + 31) / 32;
    total = nw + 2;  // one extra word probes that nothing beyond N bits is accepted
    idx = 0; gap = 0; hs_cyc = -1; tail = 0; aborted = 0; fin = 0; mism = 0;
    hdr = $urandom;
    hdr[IdW-1:0] = id[IdW-1:0];
    hdr[31:16] = n[15:0];
    base = rec_q.size(); s0 = start_cnt; d0 = done_cnt; e0 = err_cnt; v0 = viol;
    for (int b = 0; b < 4000 && tail < 4; b++) begin
      @(posedge clk); #1;
      abort = 1'b0;
      if (abort_at >= 0 && !aborted && (rec_q.size() - base - IdW) >= abort_at - 1) begin
        abort = 1'b1; aborted = 1; s_valid = 1'b0;
      end else if (!fin && !aborted && idx < total && !(idx == gap_word && gap < gap_len)) begin
        s_valid = 1'b1;
        s_data = (idx == 0) ? hdr : words[idx-1];
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
      if (done || err) begin
        fin = 1; s_valid = 1'b0;
      end
      if (idx == gap_word && gap < gap_len && s_ready) gap++;
      if (s_valid && s_ready) begin
        if (idx == 0) hs_cyc = cyc;
        idx++;
      end
      if (fin || aborted) tail++;
    end
    abort = 1'b0;
    s_valid = 1'b0;

    got_n = rec_q.size() - base;
    exp_pay = aborted ? abort_at : n;
    check_eq("start_cnt", start_cnt - s0, (n > 0) ? 1 : 0);
    if (n > 0) begin
      check_eq("start_lat", start_cyc, hs_cyc + 1);
      check_eq("id_lat", (got_n > 0) ? rec_cyc[base] : -1, hs_cyc + 2);
    end
    check_eq("valid_cnt", got_n, (n > 0) ? IdW + exp_pay : 0);
    for (int i = 0; i < got_n && i < IdW + exp_pay; i++) begin
      if (i < IdW) e = (id >> (IdW - 1 - i)) & 1;
      else e = int'(words[(i - IdW) / 32][(i - IdW) % 32]);
      if (int'(rec_q[base+i]) != e) mism++;
    end
    check_eq("bit_mism", mism, 0);
    check_eq("done_cnt", done_cnt - d0, (n > 0 && !aborted) ? 1 : 0);
    check_eq("err_cnt", err_cnt - e0, (n == 0) ? 1 : 0);
    check_eq("proto_viol", viol - v0, 0);
    check_eq("busy_end", int'(busy), 0);
    if (!aborted) check_eq("words_acc", idx, nw + 1);
    if (n > 0 && !aborted && got_n == IdW + n) begin
      check_eq("pay_span", rec_cyc[base+IdW+n-1] - rec_cyc[base+IdW],
               n - 1 + ((gap_word >= 2) ? gap_len : 0));
      check_eq("done_lat", done_cyc, rec_cyc[base+got_n-1] + 1);
    end
  endtask

  task automatic rand_words();
    for (int i = 0; i < 8; i++) words[i] = $urandom;
  endtask

  initial begin
    int n, nw, gw, gl;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", int'(s_ready), 1);
    check_eq("rst_outs", int'({cfg_in_start, cfg_bit_in, cfg_bit_in_valid, busy, done, err}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    rand_words();
    words[0] = 32'hA5A5A5A5; words[1] = 32'h0; words[2] = 32'hFFFFFFFF;
    words[3] = 32'h12345678; words[4] = 32'h0000000F;
    run_frame(5, 140, -1, 0, -1);
    run_frame(5, 140, 3, 7, -1);
    run_frame(2, 0, -1, 0, -1);
    run_frame(3, 33, -1, 0, -1);
    run_frame(4, 140, -1, 0, 40);
    run_frame(5, 140, -1, 0, -1);

    // Reset asserted asynchronously in the middle of the ID preamble.
    @(posedge clk); #1;
    s_data = 32'h0028_0006;
    s_valid = 1'b1;
    @(negedge clk);
    check_eq("rst_hdr_ready", int'(s_ready), 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk); #2;
    check_eq("pre_rst_valid", int'(cfg_bit_in_valid), 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_outs",
             int'({cfg_in_start, cfg_bit_in, cfg_bit_in_valid, busy, done, err}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_ready", int'(s_ready), 1);
    rand_words();
    run_frame(6, 70, -1, 0, -1);

    words[0] = 32'h00000001;
    run_frame(7, 1, -1, 0, -1);

    for (int k = 0; k < 8; k++) begin
      rand_words();
      n = $urandom_range(1, 224);
      nw = (n + 31) / 32;
      gw = -1; gl = 0;
      if (nw >= 3 && $urandom_range(0, 1) == 1) begin
        gw = $urandom_range(2, nw);
        gl = $urandom_range(1, 9);
      end
      run_frame($urandom_range(0, 7), n, gw, gl, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
